// File: rtl/goldschmidt_iter_ctrl_if.sv
// Handshake and multiplier bus between the Goldschmidt iteration controller and its surroundings.
// The master side issues requests and supplies the external multiplier product.
interface goldschmidt_iter_ctrl_if #(
    parameter int W = 24
);
    logic           start;
    logic [W-1:0]   n_in;
    logic [W-1:0]   d_in;
    logic           ready;
    logic           busy;
    logic           done;
    logic           err;
    logic [W-1:0]   q_out;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_x;
    logic [2*W-1:0] mul_product;

    modport master (
        output start, n_in, d_in, mul_product,
        input  ready, busy, done, err, q_out, mul_a, mul_x
    );

    modport slave (
        input  start, n_in, d_in, mul_product,
        output ready, busy, done, err, q_out, mul_a, mul_x
    );
endinterface

// File: rtl/goldschmidt_iter_ctrl.sv
// Goldschmidt divider iteration controller: holds N, D, F in Q1.23 and time-shares one external
// multiplier, spending two cycles (N*F then D*F) per iteration.
module goldschmidt_iter_ctrl #(
    parameter int W    = 24,
    parameter int ITER = 5
) (
    input logic                    clk,
    input logic                    rst,
    goldschmidt_iter_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(ITER) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_N = 2'd1,
        MUL_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       n_reg_q, n_reg_d;
    logic [W-1:0]       d_reg_q, d_reg_d;
    logic [W-1:0]       f_reg_q, f_reg_d;
    logic [W-1:0]       q_out_q, q_out_d;
    logic [CNT_W-1:0]   iter_cnt_q, iter_cnt_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic [W-1:0]       prod_t;
    logic               in_ok;
    logic               unused_prod_bits;

    // Q2.46 product back to Q1.23 by truncation; the dropped bits are zero or below one LSB.
    assign prod_t           = bus.mul_product[2*W-2:W-1];
    assign unused_prod_bits = ^{bus.mul_product[2*W-1], bus.mul_product[W-2:0]};
    assign in_ok            = (bus.n_in[W-1:W-2] == 2'b01) && (bus.d_in[W-1:W-2] == 2'b01);

    always_comb begin
        bus.mul_a = '0;
        bus.mul_x = '0;
        case (state_q)
            MUL_N: begin
                bus.mul_a = n_reg_q;
                bus.mul_x = f_reg_q;
            end
            MUL_D: begin
                bus.mul_a = d_reg_q;
                bus.mul_x = f_reg_q;
            end
            default: begin
                bus.mul_a = '0;
                bus.mul_x = '0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        n_reg_d    = n_reg_q;
        d_reg_d    = d_reg_q;
        f_reg_d    = f_reg_q;
        q_out_d    = q_out_q;
        iter_cnt_d = iter_cnt_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (!in_ok) begin
                        err_d   = 1'b1;
                        q_out_d = '0;
                        state_d = DONE;
                    end else begin
                        n_reg_d    = bus.n_in;
                        d_reg_d    = bus.d_in;
                        f_reg_d    = ~bus.d_in + W'(1);
                        iter_cnt_d = '0;
                        err_d      = 1'b0;
                        state_d    = MUL_N;
                    end
                end
            end
            MUL_N: begin
                n_reg_d = prod_t;
                state_d = MUL_D;
            end
            MUL_D: begin
                // F for the next iteration comes straight from the fresh D product.
                d_reg_d    = prod_t;
                f_reg_d    = ~prod_t + W'(1);
                iter_cnt_d = iter_cnt_q + CNT_W'(1);
                if (iter_cnt_q == CNT_W'(ITER - 1)) begin
                    q_out_d = n_reg_q;
                    state_d = DONE;
                end else begin
                    state_d = MUL_N;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == MUL_N) || (state_d == MUL_D);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            n_reg_q    <= '0;
            d_reg_q    <= '0;
            f_reg_q    <= '0;
            q_out_q    <= '0;
            iter_cnt_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_reg_q    <= n_reg_d;
            d_reg_q    <= d_reg_d;
            f_reg_q    <= f_reg_d;
            q_out_q    <= q_out_d;
            iter_cnt_q <= iter_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.q_out = q_out_q;
endmodule

// File: tb/tb_goldschmidt_iter_ctrl.sv
// Self-checking bench for goldschmidt_iter_ctrl: directed corner cases plus randomized divisions
// compared against an arithmetic Goldschmidt model and the per-cycle multiplier operand sequence.
module tb_goldschmidt_iter_ctrl;
    localparam int W    = 24;
    localparam int ITER = 5;
    localparam int NCYC = 2 * ITER;
    localparam longint unsigned TWO  = 64'h100_0000;
    localparam longint unsigned MASK = 64'h0FF_FFFF;

    logic clk = 1'b0;
    logic rst;

    goldschmidt_iter_ctrl_if #(.W(W)) bus ();

    goldschmidt_iter_ctrl #(.W(W), .ITER(ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Ideal combinational multiplier sitting downstream of the controller.
    assign bus.mul_product = {{W{1'b0}}, bus.mul_a} * {{W{1'b0}}, bus.mul_x};

    int compared   = 0;
    int mismatched = 0;
    int donePulses = 0;

    always @(posedge clk) begin
        if (bus.done === 1'b1) donePulses++;
    end

    logic [W-1:0] expA [NCYC];
    logic [W-1:0] expX [NCYC];
    logic [W-1:0] expQ;
    logic         expErr;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Goldschmidt in plain arithmetic: per iteration N*=F, D*=F, F=2-D, each product truncated to Q1.23.
    task automatic buildModel(input logic [W-1:0] n, input logic [W-1:0] d);
        longint unsigned nn, dd, ff;
        expErr = !(n >= 24'h40_0000 && n < 24'h80_0000 && d >= 24'h40_0000 && d < 24'h80_0000);
        expQ   = '0;
        if (!expErr) begin
            nn = n;
            dd = d;
            ff = (TWO - dd) & MASK;
            for (int k = 0; k < ITER; k++) begin
                expA[2*k]   = W'(nn);
                expX[2*k]   = W'(ff);
                nn          = ((nn * ff) >> 23) & MASK;
                expA[2*k+1] = W'(dd);
                expX[2*k+1] = W'(ff);
                dd          = ((dd * ff) >> 23) & MASK;
                ff          = (TWO - dd) & MASK;
            end
            expQ = W'(nn);
        end
    endtask

    task automatic waitReady();
        int guard = 0;
        while (bus.ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (bus.ready !== 1'b1) checkOutput("ready_timeout", 64'(bus.ready), 64'd1);
    endtask

    // Runs one division; stray=1 throws start pulses and junk operands at the busy/done phases.
    task automatic applyStimulus(input logic [W-1:0] n, input logic [W-1:0] d, input bit stray);
        int pulsesBefore;
        buildModel(n, d);
        waitReady();
        pulsesBefore = donePulses;
        bus.start = 1'b1;
        bus.n_in  = n;
        bus.d_in  = d;
        @(negedge clk);
        bus.start = 1'b0;
        if (!expErr) begin
            for (int c = 0; c < NCYC; c++) begin
                checkOutput($sformatf("mul_a[%0d]", c), 64'(bus.mul_a), 64'(expA[c]));
                checkOutput($sformatf("mul_x[%0d]", c), 64'(bus.mul_x), 64'(expX[c]));
                checkOutput("busy", 64'(bus.busy), 64'd1);
                checkOutput("done_early", 64'(bus.done), 64'd0);
                if (stray) begin
                    bus.start = 1'($urandom_range(0, 1));
                    bus.n_in  = W'($urandom);
                    bus.d_in  = W'($urandom);
                end
                @(negedge clk);
            end
        end
        checkOutput("done", 64'(bus.done), 64'd1);
        checkOutput("err", 64'(bus.err), 64'(expErr));
        checkOutput("q_out", 64'(bus.q_out), 64'(expQ));
        checkOutput("ready_in_done", 64'(bus.ready), 64'd0);
        checkOutput("busy_in_done", 64'(bus.busy), 64'd0);
        bus.start = stray;
        bus.n_in  = 24'h40_0000 | W'($urandom_range(0, 24'h3F_FFFF));
        bus.d_in  = 24'h40_0000 | W'($urandom_range(0, 24'h3F_FFFF));
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("done_pulse_len", 64'(bus.done), 64'd0);
        checkOutput("ready_after", 64'(bus.ready), 64'd1);
        checkOutput("q_hold", 64'(bus.q_out), 64'(expQ));
        checkOutput("err_hold", 64'(bus.err), 64'(expErr));
        checkOutput("done_count", 64'(donePulses - pulsesBefore), 64'd1);
    endtask

    task automatic checkNear(input string tag, input logic [W-1:0] q, input int target, input bit belowOnly);
        int diff;
        diff = target - int'(q);
        if (!belowOnly && diff < 0) diff = -diff;
        checkOutput(tag, 64'(diff >= 0 && diff <= 2 * ITER), 64'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"}, 64'(bus.ready), 64'd1);
        checkOutput({tag, "_busy"},  64'(bus.busy),  64'd0);
        checkOutput({tag, "_done"},  64'(bus.done),  64'd0);
        checkOutput({tag, "_err"},   64'(bus.err),   64'd0);
        checkOutput({tag, "_q"},     64'(bus.q_out), 64'd0);
        checkOutput({tag, "_mul_a"}, 64'(bus.mul_a), 64'd0);
        checkOutput({tag, "_mul_x"}, 64'(bus.mul_x), 64'd0);
    endtask

    initial begin
        int pulsesBefore;
        logic [W-1:0] rn, rd;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.n_in  = '0;
        bus.d_in  = '0;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(24'h60_0000, 24'h60_0000, 1'b0);
        checkNear("t1_near", bus.q_out, 32'h80_0000, 1'b1);
        applyStimulus(24'h7F_FFFF, 24'h40_0000, 1'b1);
        checkNear("t2_near", bus.q_out, 32'hFF_FFFE, 1'b1);
        applyStimulus(24'h40_0000, 24'h7F_FFFF, 1'b0);
        checkNear("t3_near", bus.q_out, 32'h40_0000, 1'b0);
        applyStimulus(24'h60_0000, 24'h30_0000, 1'b0);
        applyStimulus(24'h80_0000, 24'h60_0000, 1'b1);
        applyStimulus(24'h60_0000, 24'h60_0000, 1'b1);

        // Reset in the MUL_D cycle of the second iteration: no done, outputs back to reset values.
        buildModel(24'h60_0000, 24'h60_0000);
        waitReady();
        pulsesBefore = donePulses;
        bus.start = 1'b1;
        bus.n_in  = 24'h60_0000;
        bus.d_in  = 24'h60_0000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_rst_mul_a", 64'(bus.mul_a), 64'(expA[3]));
        rst = 1'b1;
        #1;
        checkResetState("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (NCYC + 2) @(negedge clk);
        checkOutput("midrst_no_done", 64'(donePulses - pulsesBefore), 64'd0);
        checkResetState("midrst_idle");
        applyStimulus(24'h60_0000, 24'h60_0000, 1'b0);
        checkNear("t6_near", bus.q_out, 32'h80_0000, 1'b1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 99) < 15) begin
                rn = W'($urandom);
                rd = W'($urandom);
            end else begin
                rn = 24'h40_0000 | W'($urandom_range(0, 24'h3F_FFFF));
                rd = 24'h40_0000 | W'($urandom_range(0, 24'h3F_FFFF));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(rn, rd, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
